// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Purpose : shared types and constants for the pipeline hazard controller.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: FSM state enum, forwarding-mux select codes, register-zero index.
package pipe_pkg;

  // RUN: normal issue. MEM_WAIT: data memory stalled. FLUSH: one bubble cycle after a taken branch.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FLUSH    = 2'b10
  } state_e;

  // ALU operand mux selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // $zero is hard-wired, so it never creates a dependency.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose : bundles the hazard-controller signals between the pipeline datapath and the controller.
// Latency : n/a (wiring only).
// Backpr. : n/a; pc_write/if_id_write/pipe_freeze are the stall controls carried here.
// Ports   : master = datapath side (drives stage info, receives enables/flushes/forward selects);
//           slave  = controller side. Perf counters exist only when PIPE_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int RA_W = 5
);
  logic [RA_W-1:0] rs_id;
  logic [RA_W-1:0] rt_id;
  logic [RA_W-1:0] rs_ex;
  logic [RA_W-1:0] rt_ex;
  logic            memread_ex;
  logic [RA_W-1:0] wr_reg_mem;
  logic [RA_W-1:0] wr_reg_wb;
  logic            regwrite_mem;
  logic            regwrite_wb;
  logic            branch_taken_mem;
  logic            mem_req;
  logic            mem_ready;

  logic            pc_write;
  logic            if_id_write;
  logic            id_ex_nop;
  logic            if_id_flush;
  logic            id_ex_flush;
  logic            ex_mem_flush;
  logic            pipe_freeze;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic            mem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]     perf_stall;
  logic [31:0]     perf_flush;
  logic [31:0]     perf_wait;
`endif

  modport master (
    output rs_id, rt_id, rs_ex, rt_ex, memread_ex,
    output wr_reg_mem, wr_reg_wb, regwrite_mem, regwrite_wb,
    output branch_taken_mem, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_nop,
    input  if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze,
    input  forward_a, forward_b, mem_timeout
`ifdef PIPE_PERF_CNT_EN
    , input perf_stall, perf_flush, perf_wait
`endif
  );

  modport slave (
    input  rs_id, rt_id, rs_ex, rt_ex, memread_ex,
    input  wr_reg_mem, wr_reg_wb, regwrite_mem, regwrite_wb,
    input  branch_taken_mem, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_nop,
    output if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze,
    output forward_a, forward_b, mem_timeout
`ifdef PIPE_PERF_CNT_EN
    , output perf_stall, perf_flush, perf_wait
`endif
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Purpose : forwarding select for one ALU operand (MEM result beats WB result beats register file).
// Latency : combinational, zero cycles.
// Backpr. : none; pure function of the current stage registers.
// Ports   : i_src = operand source reg in EX; i_wr_reg_*/i_regwrite_* = MEM/WB writers; o_fwd = mux select.
module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_src,
  input  logic [RA_W-1:0] i_wr_reg_mem,
  input  logic            i_regwrite_mem,
  input  logic [RA_W-1:0] i_wr_reg_wb,
  input  logic            i_regwrite_wb,
  output logic [1:0]      o_fwd
);

  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_mem = i_regwrite_mem && (i_wr_reg_mem != RA_W'(REG_ZERO)) && (i_wr_reg_mem == i_src);
  assign w_hit_wb  = i_regwrite_wb  && (i_wr_reg_wb  != RA_W'(REG_ZERO)) && (i_wr_reg_wb  == i_src);

  // MEM holds the younger write, so it wins when both stages target the same register.
  assign o_fwd = w_hit_mem ? FWD_MEM : (w_hit_wb ? FWD_WB : FWD_RF);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : unified load-use stall, EX forwarding, taken-branch flush and data-memory wait freeze.
// Latency : all controls combinational in the current cycle; FSM/timeout/flush_pend registered.
// Backpr. : drops pc_write/if_id_write on a stall; raises pipe_freeze while memory is not ready.
// Ports   : clk, rst_n (async active-low); hz = pipeline_hazard_ctrl_if.slave bundle.
// Option  : define PIPE_PERF_CNT_EN to add perf_stall/perf_flush/perf_wait counters to the bundle.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_flush_pend;
  logic              w_flush_pend_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;

  logic              w_load_use;
  logic              w_mem_stall;
  logic              w_wait_done;
  logic              w_pc_write;
  logic              w_if_id_write;
  logic              w_nop;
  logic              w_flush;
  logic              w_freeze;

  pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .i_src          (hz.rs_ex),
    .i_wr_reg_mem   (hz.wr_reg_mem),
    .i_regwrite_mem (hz.regwrite_mem),
    .i_wr_reg_wb    (hz.wr_reg_wb),
    .i_regwrite_wb  (hz.regwrite_wb),
    .o_fwd          (hz.forward_a)
  );

  pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .i_src          (hz.rt_ex),
    .i_wr_reg_mem   (hz.wr_reg_mem),
    .i_regwrite_mem (hz.regwrite_mem),
    .i_wr_reg_wb    (hz.wr_reg_wb),
    .i_regwrite_wb  (hz.regwrite_wb),
    .o_fwd          (hz.forward_b)
  );

  assign w_load_use  = hz.memread_ex && (hz.rt_ex != RA_W'(REG_ZERO)) &&
                       ((hz.rt_ex == hz.rs_id) || (hz.rt_ex == hz.rt_id));
  assign w_mem_stall = hz.mem_req && !hz.mem_ready;
  assign w_wait_done = hz.mem_ready || (r_wait_cnt >= WAIT_W'(WAIT_MAX));

  always_comb begin
    w_state_nxt      = r_state;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_flush_pend_nxt = r_flush_pend;
    w_timeout_nxt    = r_timeout;
    w_pc_write       = 1'b1;
    w_if_id_write    = 1'b1;
    w_nop            = 1'b0;
    w_flush          = 1'b0;
    w_freeze         = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          // The entry cycle is already a frozen cycle, so it counts as the first wait.
          w_freeze         = 1'b1;
          w_pc_write       = 1'b0;
          w_if_id_write    = 1'b0;
          w_wait_cnt_nxt   = WAIT_W'(1);
          w_flush_pend_nxt = hz.branch_taken_mem;
          w_state_nxt      = MEM_WAIT;
        end else if (hz.branch_taken_mem) begin
          w_flush     = 1'b1;
          w_state_nxt = FLUSH;
        end else if (w_load_use) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_nop         = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (w_wait_done) begin
          w_wait_cnt_nxt = '0;
          if (!hz.mem_ready) begin
            w_timeout_nxt = 1'b1;
          end
          // The branch is frozen in MEM, so a live branch_taken_mem here is the same event.
          if (r_flush_pend || hz.branch_taken_mem) begin
            w_flush          = 1'b1;
            w_flush_pend_nxt = 1'b0;
            w_state_nxt      = FLUSH;
          end else begin
            w_state_nxt = RUN;
            // The pipe advances this cycle, so a load-use pair in ID/EX still needs its bubble.
            if (w_load_use) begin
              w_pc_write    = 1'b0;
              w_if_id_write = 1'b0;
              w_nop         = 1'b1;
            end
          end
        end else begin
          w_freeze       = 1'b1;
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          if (hz.branch_taken_mem) begin
            w_flush_pend_nxt = 1'b1;
          end
        end
      end

      FLUSH: begin
        // ID holds the bubble from the flush, so no load-use check this cycle.
        w_state_nxt = RUN;
      end

      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign hz.pc_write     = w_pc_write;
  assign hz.if_id_write  = w_if_id_write;
  assign hz.id_ex_nop    = w_nop;
  assign hz.if_id_flush  = w_flush;
  assign hz.id_ex_flush  = w_flush;
  assign hz.ex_mem_flush = w_flush;
  assign hz.pipe_freeze  = w_freeze;
  assign hz.mem_timeout  = r_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_wait  <= '0;
    end else begin
      if (w_nop)    r_perf_stall <= r_perf_stall + 32'd1;
      if (w_flush)  r_perf_flush <= r_perf_flush + 32'd1;
      if (w_freeze) r_perf_wait  <= r_perf_wait  + 32'd1;
    end
  end

  assign hz.perf_stall = r_perf_stall;
  assign hz.perf_flush = r_perf_flush;
  assign hz.perf_wait  = r_perf_wait;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised successor to the separate hazard-detection and forwarding units of the 5-stage MIPS pipeline. It merges load-use stalling, EX forwarding select, taken-branch flushing and a variable-latency data-memory wait freeze into one sequential controller. It sits beside the IF_ID, ID_EX, EX_MEM and MEM_WB registers and drives their enables and flushes, plus the ALU operand forwarding muxes.

Parameters:
RA_W, 5, register-address width.
WAIT_MAX, 15, max data-memory wait cycles before timeout (1..255).
WAIT_W, 8, width of the wait counter.

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs_id, rt_id  in  RA_W  source registers of the instruction in ID
rs_ex, rt_ex  in  RA_W  source registers of the instruction in EX
memread_ex  in  1  load in EX
wr_reg_mem, wr_reg_wb  in  RA_W  destination registers in MEM and WB
regwrite_mem, regwrite_wb  in  1  write enables in MEM and WB
branch_taken_mem  in  1  Branch_MEM & Zero_MEM
mem_req  in  1  MemRead_MEM | MemWrite_MEM
mem_ready  in  1  data memory completes this cycle
pc_write, if_id_write  out  1  PC and IF_ID enables
id_ex_nop  out  1  zero the ID-stage control bits
if_id_flush, id_ex_flush, ex_mem_flush  out  1  synchronous clear of the register
pipe_freeze  out  1  hold ID_EX, EX_MEM and MEM_WB
forward_a, forward_b  out  2  00 = register file, 10 = MEM result, 01 = WB result
mem_timeout  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to RUN; wait_cnt=0; flush_pend=0; mem_timeout=0.
  - Outputs: pc_write=1, if_id_write=1, every flush, nop and freeze output 0, forward_* 00.
- Forwarding (combinational, also valid in every state):
  - forward_a=10 if regwrite_mem && wr_reg_mem!=0 && wr_reg_mem==rs_ex.
  - Else forward_a=01 under the same test against WB.
  - Else forward_a=00.
  - forward_b uses rt_ex in the same way. MEM has priority over WB.
- Register 0 never causes forwarding or a stall.
- FSM states: RUN, MEM_WAIT, FLUSH.
- RUN:
  - If mem_req && !mem_ready: go to MEM_WAIT.
  - Else if branch_taken_mem: assert if_id_flush, id_ex_flush and ex_mem_flush for this cycle, and go to FLUSH.
  - Else if load-use (memread_ex && rt_ex!=0 && (rt_ex==rs_id || rt_ex==rt_id)): pc_write=0, if_id_write=0, id_ex_nop=1. This gives exactly one bubble, since the load leaves EX next cycle.
- MEM_WAIT:
  - pipe_freeze=1, pc_write=0, if_id_write=0. wait_cnt increments each cycle.
  - A branch_taken_mem seen on entry or while waiting sets flush_pend.
  - Exit on mem_ready, or when wait_cnt==WAIT_MAX (then set mem_timeout, sticky until reset, and force exit).
  - Exit cycle: freeze released and wait_cnt cleared. If flush_pend is set, perform the three flushes in that cycle, clear flush_pend and go to FLUSH; otherwise go to RUN.
- FLUSH:
  - Lasts one cycle. Load-use detection is suppressed, because ID holds a bubble.
  - Returns to RUN.
- Priority on simultaneous events: memory wait > branch flush > load-use stall.
- Freeze semantics: a stall or freeze never drops the flush. A flush during a load-use stall overrides the stall: pc_write=1 so the branch target loads.
- wait_cnt saturates at WAIT_MAX, with no wrap. Reset mid-wait abandons the wait with no flush.

Optional Feature:
PIPE_PERF_CNT_EN:
- When defined, adds three 32-bit outputs: perf_stall (load-use bubbles), perf_flush (flush events) and perf_wait (frozen cycles).
- Each counter wraps at 2^32 and is cleared by rst_n.
- When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state enum (RUN, MEM_WAIT, FLUSH).
  - Forward select constants FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
  - REG_ZERO.
- One sub-module, pipe_fwd_sel: purely combinational forwarding compare, instantiated twice (operands A and B).

Test Plan:
1. lw $2 in EX, ID uses rs=2 -> one cycle with pc_write=0, if_id_write=0, id_ex_nop=1; next cycle with rs_ex=2 and load in WB gives forward_a=01.
2. wr_reg_mem=wr_reg_wb=3, both regwrite, rs_ex=3 -> forward_a=10. Same case with destination register 0 -> 00.
3. branch_taken_mem=1 in RUN -> three flushes high for 1 cycle, state FLUSH, then RUN. A simultaneous load-use does not produce id_ex_nop.
4. mem_req=1, mem_ready low for 4 cycles -> pipe_freeze high for exactly 4 cycles, released on the mem_ready cycle.
5. mem_ready never asserted, WAIT_MAX=15 -> mem_timeout rises after 15 frozen cycles, stays high, and the pipeline resumes.
6. branch_taken_mem during MEM_WAIT, then rst_n pulsed mid-wait on a second run -> first run flushes exactly in the release cycle; after reset all outputs return to reset values with no flush.
